// File: rtl/asrv32_wb_ctrl_if.sv
// Writeback controller bus: ALU and load result channels, regfile write port and forwarding lookup.
// The controller uses the slave modport; the producing pipeline uses master.
interface asrv32_wb_ctrl_if;
    logic        i_alu_vld;
    logic        o_alu_rdy;
    logic [4:0]  i_alu_rd_addr;
    logic [31:0] i_alu_rd_data;

    logic        i_ld_vld;
    logic        o_ld_rdy;
    logic [4:0]  i_ld_rd_addr;
    logic [31:0] i_ld_data;
    logic [2:0]  i_ld_funct3;
    logic [1:0]  i_ld_addr_lo;

    logic        i_stall;
    logic        o_ce_wr;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;

    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        o_fwd_rs1_hit;
    logic [31:0] o_fwd_rs1_data;
    logic        o_fwd_rs2_hit;
    logic [31:0] o_fwd_rs2_data;

    modport master (
        output i_alu_vld, i_alu_rd_addr, i_alu_rd_data,
        output i_ld_vld, i_ld_rd_addr, i_ld_data, i_ld_funct3, i_ld_addr_lo,
        output i_stall, i_rs1_addr, i_rs2_addr,
        input  o_alu_rdy, o_ld_rdy, o_ce_wr, o_rd_addr, o_rd_data,
        input  o_fwd_rs1_hit, o_fwd_rs1_data, o_fwd_rs2_hit, o_fwd_rs2_data
    );

    modport slave (
        input  i_alu_vld, i_alu_rd_addr, i_alu_rd_data,
        input  i_ld_vld, i_ld_rd_addr, i_ld_data, i_ld_funct3, i_ld_addr_lo,
        input  i_stall, i_rs1_addr, i_rs2_addr,
        output o_alu_rdy, o_ld_rdy, o_ce_wr, o_rd_addr, o_rd_data,
        output o_fwd_rs1_hit, o_fwd_rs1_data, o_fwd_rs2_hit, o_fwd_rs2_data
    );
endinterface

// File: rtl/asrv32_wb_ctrl.sv
// Writeback controller: merges ALU and load results into an in-order pending-write FIFO feeding the
// regfile write port. Define ASRV32_WB_FWD_EN to enable forwarding of pending writes to operand fetch.
module asrv32_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    asrv32_wb_ctrl_if.slave  bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          ce_q;
    logic [4:0]    rd_addr_q;
    logic [31:0]   rd_data_q;

    logic          not_full;
    logic          fifo_empty;
    logic          alu_acc;
    logic          ld_acc;
    logic [4:0]    acc_addr;
    logic [31:0]   acc_data;
    logic          store;
    logic          pop;
    logic          bypass;
    logic          push;

    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_fmt;

    assign not_full   = (count != FULL);
    assign fifo_empty = (count == '0);

    // ALU has priority, so the load channel is only offered when the ALU is idle.
    assign bus.o_alu_rdy = ~i_rst & not_full;
    assign bus.o_ld_rdy  = ~i_rst & not_full & ~bus.i_alu_vld;

    assign alu_acc = bus.i_alu_vld & bus.o_alu_rdy;
    assign ld_acc  = bus.i_ld_vld & bus.o_ld_rdy;

    always_comb begin
        ld_byte = bus.i_ld_data[{bus.i_ld_addr_lo, 3'b000} +: 8];
        ld_half = bus.i_ld_data[{bus.i_ld_addr_lo[1], 4'b0000} +: 16];
        case (bus.i_ld_funct3)
            3'd0:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_fmt = {24'd0, ld_byte};
            3'd5:    ld_fmt = {16'd0, ld_half};
            default: ld_fmt = bus.i_ld_data;
        endcase
    end

    assign acc_addr = alu_acc ? bus.i_alu_rd_addr : bus.i_ld_rd_addr;
    assign acc_data = alu_acc ? bus.i_alu_rd_data : ld_fmt;

    // Writes to x0 complete the handshake but are dropped here.
    assign store  = (alu_acc | ld_acc) & (acc_addr != 5'd0);
    assign pop    = ~bus.i_stall & ~fifo_empty;
    assign bypass = ~bus.i_stall & fifo_empty & store;
    assign push   = store & ~bypass;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= acc_addr;
            fifo_data[wr_ptr] <= acc_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ce_q      <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
        end else if (bus.i_stall) begin
            ce_q <= 1'b0;
        end else if (!fifo_empty) begin
            ce_q      <= 1'b1;
            rd_addr_q <= fifo_addr[rd_ptr];
            rd_data_q <= fifo_data[rd_ptr];
        end else if (store) begin
            ce_q      <= 1'b1;
            rd_addr_q <= acc_addr;
            rd_data_q <= acc_data;
        end else begin
            ce_q <= 1'b0;
        end
    end

    assign bus.o_ce_wr   = ce_q;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_rd_data = rd_data_q;

`ifdef ASRV32_WB_FWD_EN
    logic          fwd1_hit;
    logic [31:0]   fwd1_data;
    logic          fwd2_hit;
    logic [31:0]   fwd2_data;
    logic [AW-1:0] fwd_idx;

    // Scan oldest to newest (output register first) so the newest match overwrites older ones.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = 32'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 32'd0;
        fwd_idx   = '0;
        if (ce_q) begin
            if ((bus.i_rs1_addr != 5'd0) && (rd_addr_q == bus.i_rs1_addr)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = rd_data_q;
            end
            if ((bus.i_rs2_addr != 5'd0) && (rd_addr_q == bus.i_rs2_addr)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = rd_data_q;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + AW'(i);
            if ((AW+1)'(i) < count) begin
                if ((bus.i_rs1_addr != 5'd0) && (fifo_addr[fwd_idx] == bus.i_rs1_addr)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = fifo_data[fwd_idx];
                end
                if ((bus.i_rs2_addr != 5'd0) && (fifo_addr[fwd_idx] == bus.i_rs2_addr)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = fifo_data[fwd_idx];
                end
            end
        end
    end

    assign bus.o_fwd_rs1_hit  = fwd1_hit;
    assign bus.o_fwd_rs1_data = fwd1_data;
    assign bus.o_fwd_rs2_hit  = fwd2_hit;
    assign bus.o_fwd_rs2_data = fwd2_data;
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{bus.i_rs1_addr, bus.i_rs2_addr};

    assign bus.o_fwd_rs1_hit  = 1'b0;
    assign bus.o_fwd_rs1_data = 32'd0;
    assign bus.o_fwd_rs2_hit  = 1'b0;
    assign bus.o_fwd_rs2_data = 32'd0;
`endif

endmodule
